// File: rtl/cam_pkg.sv
// Shared constants and types for the parameterised CAM.
package cam_pkg;

    localparam int CAM_DEFAULT_DATA_W = 32;
    localparam int CAM_DEFAULT_DEPTH  = 32;

    // One bit per entry, set where that entry matches the search key.
    typedef logic [CAM_DEFAULT_DEPTH-1:0] cam_match_t;

endpackage

// File: rtl/cam_prio_enc.sv
// Lowest-index priority encoder over the CAM match vector, with hit and multi-hit flags.
module cam_prio_enc #(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] match,
    output logic [IDX_W-1:0] index,
    output logic             hit,
    output logic             multi
);

    always_comb begin
        index = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) index = i[IDX_W-1:0];
        end
    end

    assign hit   = |match;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(match & (match - 1'b1));

endmodule

// File: rtl/param_cam.sv
// Parameterised CAM with read/write/delete/search ports and a valid-entry count.
// Optional CAM_TERNARY_EN adds search_mask_i (1 = key bit is don't-care).
module param_cam
    import cam_pkg::*;
#(
    parameter  int DATA_W = CAM_DEFAULT_DATA_W,
    parameter  int DEPTH  = CAM_DEFAULT_DEPTH,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              read_enable_i,
    input  logic [IDX_W-1:0]  read_index_i,
    input  logic              write_enable_i,
    input  logic [IDX_W-1:0]  write_index_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic              delete_enable_i,
    input  logic [IDX_W-1:0]  delete_index_i,
    input  logic              search_enable_i,
    input  logic [DATA_W-1:0] search_data_i,
`ifdef CAM_TERNARY_EN
    input  logic [DATA_W-1:0] search_mask_i,
`endif
    output logic              read_valid_o,
    output logic [DATA_W-1:0] read_value_o,
    output logic              search_valid_o,
    output logic [IDX_W-1:0]  search_index_o,
    output logic              search_multi_o,
    output logic [IDX_W:0]    count_o,
    output logic              full_o,
    output logic              empty_o
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("param_cam: DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [IDX_W:0]    count_q, count_d;
    logic [DEPTH-1:0]  match;
    logic [DATA_W-1:0] care_mask;
    logic [IDX_W-1:0]  enc_index;
    logic              enc_hit, enc_multi;
    logic              inc, dec;

`ifdef CAM_TERNARY_EN
    assign care_mask = ~search_mask_i;
`else
    assign care_mask = '1;
`endif

    // Matching uses pre-update contents, so same-cycle writes are invisible to search.
    always_comb begin
        match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match[i] = valid_q[i] && (((mem[i] ^ search_data_i) & care_mask) == '0);
        end
    end

    cam_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
        .match (match),
        .index (enc_index),
        .hit   (enc_hit),
        .multi (enc_multi)
    );

    // Write beats delete on the same index, so the delete is suppressed there.
    always_comb begin
        inc     = write_enable_i && !valid_q[write_index_i];
        dec     = delete_enable_i && valid_q[delete_index_i] &&
                  !(write_enable_i && (write_index_i == delete_index_i));
        valid_d = valid_q;
        if (delete_enable_i) valid_d[delete_index_i] = 1'b0;
        if (write_enable_i)  valid_d[write_index_i]  = 1'b1;
        case ({inc, dec})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q        <= '0;
            count_q        <= '0;
            read_valid_o   <= 1'b0;
            read_value_o   <= '0;
            search_valid_o <= 1'b0;
            search_index_o <= '0;
            search_multi_o <= 1'b0;
        end else begin
            valid_q        <= valid_d;
            count_q        <= count_d;
            read_valid_o   <= read_enable_i && valid_q[read_index_i];
            read_value_o   <= (read_enable_i && valid_q[read_index_i]) ? mem[read_index_i] : '0;
            search_valid_o <= search_enable_i && enc_hit;
            search_index_o <= (search_enable_i && enc_hit) ? enc_index : '0;
            search_multi_o <= search_enable_i && enc_multi;
        end
    end

    // Entry data is not reset; the valid bits alone qualify it.
    always_ff @(posedge clk_i) begin
        if (write_enable_i) mem[write_index_i] <= write_data_i;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == (IDX_W + 1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: doc/param_cam.md
PARAM_CAM -- requirements
Module: param_cam

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 32, as the entry and search-key width in bits.
REQ-002 The block SHALL provide parameter DEPTH, default 32, as the number of entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL provide localparam IDX_W, value clog2(DEPTH), as the index width.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk_i  in  1  clock, all state on rising edge.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 read_enable_i  in  1  read request; read_index_i  in  IDX_W  read address.
REQ-008 write_enable_i  in  1  write request; write_index_i  in  IDX_W  address; write_data_i  in  DATA_W  data.
REQ-009 delete_enable_i  in  1  invalidate request; delete_index_i  in  IDX_W  address.
REQ-010 search_enable_i  in  1  search request; search_data_i  in  DATA_W  key.
REQ-011 read_valid_o  out  1  read hit; read_value_o  out  DATA_W  read data.
REQ-012 search_valid_o  out  1  search hit; search_index_o  out  IDX_W  lowest matching index; search_multi_o  out  1  more than one entry matched.
REQ-013 count_o  out  IDX_W+1  number of valid entries; full_o  out  1  count equals DEPTH; empty_o  out  1  count equals 0.

Function
REQ-014 Each entry SHALL hold a DATA_W data register and a valid bit.
REQ-015 Read, write, delete and search SHALL be accepted in the same cycle, with no stall or back-pressure.
REQ-016 Read SHALL have 1-cycle latency: read_valid_o = registered read_enable_i AND valid[read_index_i]; read_value_o = entry data if hit, else 0.
REQ-017 Search SHALL have 1-cycle latency and SHALL compare only valid entries.
REQ-018 For search, search_valid_o SHALL be 1 if any match; search_index_o SHALL be the lowest matching index, else 0; search_multi_o SHALL be 1 if two or more entries match.
REQ-019 All outputs except count_o, full_o and empty_o SHALL be high for exactly one cycle per request, and SHALL be 0 otherwise.
REQ-020 Read and search SHALL see contents from before any write or delete in the same cycle.
REQ-021 Write SHALL store data and set valid; count SHALL increment only if the entry was invalid.
REQ-022 Delete SHALL clear valid; count SHALL decrement only if the entry was valid; delete of an invalid entry SHALL be a no-op.
REQ-023 Write and delete to the same index in one cycle: write SHALL win, entry valid, count adjusted as a plain write.
REQ-024 Write and delete to different indices SHALL both take effect; count SHALL update by the net change.
REQ-025 Writing all DEPTH entries SHALL give count_o=DEPTH with no wrap; full_o and empty_o SHALL derive combinationally from count_o.

Reset
REQ-026 Assertion of rst_ni SHALL asynchronously clear all valid bits, count_o, read_valid_o, read_value_o, search_valid_o, search_index_o and search_multi_o to 0; empty_o SHALL read 1.
REQ-027 Entry data registers SHALL not be reset.
REQ-028 A request in flight when reset asserts SHALL be discarded; the first request after deassertion SHALL behave normally.

Configuration
REQ-029 Macro CAM_TERNARY_EN defined: port search_mask_i  in  DATA_W SHALL exist; a mask bit of 1 SHALL make that key bit don't-care in every entry comparison.
REQ-030 CAM_TERNARY_EN undefined: search_mask_i SHALL be absent and search SHALL be exact-match.

Structure
REQ-031 Package cam_pkg SHALL hold the default constants CAM_DEFAULT_DATA_W=32 and CAM_DEFAULT_DEPTH=32, plus a typedef for the per-entry match vector width helper.
REQ-032 Sub-module cam_prio_enc, parametrised by DEPTH, SHALL map the DEPTH-bit match vector to lowest index, hit and multi flags.

Verification
REQ-033 Reset, then search 0x0 -> search_valid_o=0, count_o=0, empty_o=1.
REQ-034 Write 0xDEADBEEF at 5 and at 9, then search 0xDEADBEEF -> search_valid_o=1, index 5, search_multi_o=1; read index 9 -> 0xDEADBEEF, read_valid_o=1.
REQ-035 Write index 3 and delete index 3 in the same cycle -> entry 3 valid, count_o=1; the next-cycle delete 3 -> count_o=0, read 3 gives read_valid_o=0 and value 0.
REQ-036 Write 0x11 at index 2 while searching 0x11 in the same cycle -> miss; the same search next cycle -> hit, index 2.
REQ-037 Write all 32 indices -> full_o=1, count_o=32; rewrite index 0 -> count_o stays 32.
REQ-038 With CAM_TERNARY_EN: entry 7=0x0000ABCD, key 0x0000AB00, mask 0x000000FF -> hit, index 7; mask 0 -> miss.
